usb_rx_pkt_ctrl: RTL and testbench



---
 rtl/usb_rx_pkt_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_usb_rx_pkt_ctrl.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_rx_pkt_ctrl.sv
// USB receive packet controller: drains the RX FIFO, checks the PID byte, streams
// payload over valid/ready and frames each packet with done/error pulses.
module usb_rx_pkt_ctrl #(
    parameter int MAX_BYTES = 64,
    parameter int CW        = $clog2(MAX_BYTES + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [7:0]    rx_data,
    input  logic          rx_empty,
    input  logic          rx_rcving,
    input  logic          rx_error,
    output logic          rx_ren,
    output logic [3:0]    pid,
    output logic          pid_valid,
    output logic [7:0]    out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          pkt_done,
    output logic          pkt_err,
    output logic [1:0]    err_code,
    output logic [CW-1:0] byte_count,
    output logic          busy
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PID   = 3'd1,
        S_DATA  = 3'd2,
        S_END   = 3'd3,
        S_ERR   = 3'd4,
        S_FLUSH = 3'd5
    } state_t;

    localparam logic [CW-1:0] MAX_CNT  = CW'(MAX_BYTES);
    localparam logic [1:0]    ERR_NONE = 2'd0;
    localparam logic [1:0]    ERR_PID  = 2'd1;
    localparam logic [1:0]    ERR_RX   = 2'd2;
    localparam logic [1:0]    ERR_OVF  = 2'd3;

    // A PID byte carries its own type in the low nibble and the complement above it.
    function automatic logic pid_ok(input logic [7:0] b);
        return (b[7:4] == ~b[3:0]);
    endfunction

    state_t          state_q, state_d;
    logic [7:0]      hold_q;
    logic [3:0]      pid_q;
    logic            pid_valid_q;
    logic [7:0]      out_data_q;
    logic            out_valid_q;
    logic            pkt_done_q;
    logic            pkt_err_q;
    logic [1:0]      err_code_q;
    logic [CW-1:0]   byte_count_q;
    logic            ren_s;
    logic [1:0]      code_s;

    // Next-state, FIFO pop and fault code selection; rx_error outranks every other event.
    always_comb begin
        state_d = state_q;
        ren_s   = 1'b0;
        code_s  = ERR_NONE;
        case (state_q)
            S_IDLE: begin
                if (!rx_empty) begin
                    ren_s   = 1'b1;
                    state_d = S_PID;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_PID: begin
                if (rx_error) begin
                    state_d = S_ERR;
                    code_s  = ERR_RX;
                end else if (!pid_ok(hold_q)) begin
                    state_d = S_ERR;
                    code_s  = ERR_PID;
                end else begin
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (rx_error) begin
                    state_d = S_ERR;
                    code_s  = ERR_RX;
                end else if ((byte_count_q == MAX_CNT) && !rx_empty) begin
                    state_d = S_ERR;
                    code_s  = ERR_OVF;
                end else if (!rx_rcving && rx_empty) begin
                    state_d = S_END;
                end else if (!rx_empty && (!out_valid_q || out_ready)) begin
                    ren_s = 1'b1;
                end else begin
                    state_d = S_DATA;
                end
            end
            S_END: begin
                if (rx_error) begin
                    state_d = S_ERR;
                    code_s  = ERR_RX;
                end else if (!out_valid_q) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_END;
                end
            end
            S_ERR: begin
                state_d = S_FLUSH;
            end
            S_FLUSH: begin
                ren_s = !rx_empty;
                if (rx_empty && !rx_rcving) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_FLUSH;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and registered outputs; a fault entry overrides any pending payload byte.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            hold_q       <= 8'h00;
            pid_q        <= 4'h0;
            pid_valid_q  <= 1'b0;
            out_data_q   <= 8'h00;
            out_valid_q  <= 1'b0;
            pkt_done_q   <= 1'b0;
            pkt_err_q    <= 1'b0;
            err_code_q   <= ERR_NONE;
            byte_count_q <= '0;
        end else begin
            state_q     <= state_d;
            pid_valid_q <= 1'b0;
            pkt_done_q  <= 1'b0;
            pkt_err_q   <= 1'b0;
            if ((state_q == S_IDLE) && ren_s) begin
                hold_q       <= rx_data;
                byte_count_q <= '0;
                err_code_q   <= ERR_NONE;
                if (pid_ok(rx_data)) begin
                    pid_q       <= rx_data[3:0];
                    pid_valid_q <= 1'b1;
                end
            end
            if ((state_q == S_DATA) && ren_s) begin
                out_data_q  <= rx_data;
                out_valid_q <= 1'b1;
                if (byte_count_q != MAX_CNT) begin
                    byte_count_q <= byte_count_q + CW'(1);
                end
            end else if (out_valid_q && out_ready) begin
                out_valid_q <= 1'b0;
            end
            if ((state_q == S_END) && (state_d == S_IDLE)) begin
                pkt_done_q <= 1'b1;
            end
            if (state_d == S_ERR) begin
                out_valid_q <= 1'b0;
                err_code_q  <= code_s;
                pkt_err_q   <= 1'b1;
            end
        end
    end

    assign rx_ren     = ren_s & ~rst;
    assign pid        = pid_q;
    assign pid_valid  = pid_valid_q;
    assign out_data   = out_data_q;
    assign out_valid  = out_valid_q;
    assign pkt_done   = pkt_done_q;
    assign pkt_err    = pkt_err_q;
    assign err_code   = err_code_q;
    assign byte_count = byte_count_q;
    assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_usb_rx_pkt_ctrl.sv
// Bench for usb_rx_pkt_ctrl: queue-modelled FIFO, table of packet vectors, directed
// corner sequences and random packets scored against a packet-level model.
module tb_usb_rx_pkt_ctrl;
    localparam int MAXB = 4;
    localparam int CW   = $clog2(MAXB + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [7:0]    rx_data = 8'h00;
    logic          rx_empty = 1'b1;
    logic          rx_rcving = 1'b0;
    logic          rx_error = 1'b0;
    logic          rx_ren;
    logic [3:0]    pid;
    logic          pid_valid;
    logic [7:0]    out_data;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic          pkt_done;
    logic          pkt_err;
    logic [1:0]    err_code;
    logic [CW-1:0] byte_count;
    logic          busy;

    always #5 clk = ~clk;

    usb_rx_pkt_ctrl #(.MAX_BYTES(MAXB), .CW(CW)) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_empty(rx_empty),
        .rx_rcving(rx_rcving), .rx_error(rx_error), .rx_ren(rx_ren), .pid(pid),
        .pid_valid(pid_valid), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .pkt_done(pkt_done), .pkt_err(pkt_err),
        .err_code(err_code), .byte_count(byte_count), .busy(busy)
    );

    typedef struct {
        logic [7:0][7:0] b;
        int              len;
        int              mode;
        logic [1:0]      e_err;
        int              e_nout;
        int              e_done;
        int              e_errp;
        int              e_pidv;
        logic [3:0]      e_pid;
        int              e_cnt;
    } vec_t;

    int         total = 0;
    int         bad = 0;
    int         cyc = 0;
    logic [7:0] fifo[$];
    logic [7:0] got[$];
    int         got_cyc[$];
    int         pidv_n, done_n, errp_n, pidv_cyc, first_pop_cyc;
    logic [3:0] pidv_val;
    int         viol_empty = 0, viol_stall = 0, viol_excl = 0;
    int         ready_mode = 0, tog_idx = 0;
    logic       ren_tb;
    logic [3:0] model_pid;
    vec_t       vt[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_fifo();
        rx_empty = (fifo.size() == 0);
        rx_data  = rx_empty ? 8'h00 : fifo[0];
    endtask

    task automatic clear_mon();
        got.delete();
        got_cyc.delete();
        pidv_n = 0; done_n = 0; errp_n = 0; pidv_cyc = -1; first_pop_cyc = -1;
        pidv_val = 4'h0;
    endtask

    // Called at posedge+1: apply inputs, sample at negedge, pop after the next edge.
    task automatic cycle_step(input logic push_en, input logic [7:0] push_b);
        if (push_en) fifo.push_back(push_b);
        case (ready_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'($urandom_range(0, 1));
            2:       out_ready = ((tog_idx % 3) == 0);
            default: out_ready = 1'b0;
        endcase
        tog_idx++;
        drive_fifo();
        @(negedge clk);
        ren_tb = rx_ren;
        if (rx_ren && rx_empty) viol_empty++;
        if (rx_ren && out_valid && !out_ready) viol_stall++;
        if ((int'(pid_valid) + int'(pkt_done) + int'(pkt_err)) > 1) viol_excl++;
        if (rx_ren && first_pop_cyc < 0) first_pop_cyc = cyc;
        if (out_valid && out_ready) begin
            got.push_back(out_data);
            got_cyc.push_back(cyc);
        end
        if (pid_valid) begin
            pidv_n++;
            pidv_cyc = cyc;
            pidv_val = pid;
        end
        if (pkt_done) done_n++;
        if (pkt_err) errp_n++;
        @(posedge clk);
        #1;
        cyc++;
        if (ren_tb && fifo.size() > 0) void'(fifo.pop_front());
        drive_fifo();
    endtask

    task automatic wait_idle(input string nm);
        int k;
        k = 0;
        while ((busy || fifo.size() != 0) && k < 300) begin
            cycle_step(1'b0, 8'h00);
            k++;
        end
        check({nm, "_timeout"}, 32'(k < 300), 32'd1);
        cycle_step(1'b0, 8'h00);
        cycle_step(1'b0, 8'h00);
    endtask

    task automatic send_pkt(input logic [7:0] b[$], input int mode, input int gaps);
        clear_mon();
        ready_mode = mode;
        tog_idx    = 0;
        rx_rcving  = 1'b1;
        foreach (b[i]) begin
            repeat ($urandom_range(0, gaps)) cycle_step(1'b0, 8'h00);
            cycle_step(1'b1, b[i]);
        end
        repeat ($urandom_range(0, 2)) cycle_step(1'b0, 8'h00);
        rx_rcving = 1'b0;
        wait_idle("pkt");
    endtask

    // Packet-level reference: outcome follows only from the PID rule, payload length and MAXB.
    task automatic model_check(input logic [7:0] b[$], input int mode, input string nm);
        logic [7:0] pb;
        int         n;
        logic       ok;
        pb = b[0];
        n  = b.size() - 1;
        ok = (pb[7:4] == ~pb[3:0]);
        if (!ok) begin
            check({nm, "_nout"}, got.size(), 0);
            check({nm, "_done"}, done_n, 0);
            check({nm, "_errp"}, errp_n, 1);
            check({nm, "_pidv"}, pidv_n, 0);
            check({nm, "_code"}, err_code, 2'd1);
            check({nm, "_cnt"}, byte_count, 0);
        end else begin
            model_pid = pb[3:0];
            check({nm, "_pidv"}, pidv_n, 1);
            if (n > MAXB) begin
                if (mode == 0) check({nm, "_nout"}, got.size(), MAXB);
                else check({nm, "_nout_rng"}, 32'(got.size() >= MAXB - 1 && got.size() <= MAXB), 32'd1);
                check({nm, "_done"}, done_n, 0);
                check({nm, "_errp"}, errp_n, 1);
                check({nm, "_code"}, err_code, 2'd3);
                check({nm, "_cnt"}, byte_count, MAXB);
            end else begin
                check({nm, "_nout"}, got.size(), n);
                check({nm, "_done"}, done_n, 1);
                check({nm, "_errp"}, errp_n, 0);
                check({nm, "_code"}, err_code, 2'd0);
                check({nm, "_cnt"}, byte_count, n);
            end
        end
        for (int i = 0; i < got.size() && i < n; i++) check({nm, "_byte"}, got[i], b[i + 1]);
        check({nm, "_pid"}, pid, model_pid);
        check({nm, "_flushed"}, fifo.size(), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] q[$];
        logic [7:0] pb;
        logic [3:0] p;
        int         n, mode;

        vt[0] = '{b: {8'h00, 8'h00, 8'h00, 8'h00, 8'h33, 8'h22, 8'h11, 8'hC3}, len: 4, mode: 0,
                  e_err: 2'd0, e_nout: 3, e_done: 1, e_errp: 0, e_pidv: 1, e_pid: 4'h3, e_cnt: 3};
        vt[1] = '{b: {8'h00, 8'h00, 8'h00, 8'h00, 8'h33, 8'h22, 8'h11, 8'hC3}, len: 4, mode: 2,
                  e_err: 2'd0, e_nout: 3, e_done: 1, e_errp: 0, e_pidv: 1, e_pid: 4'h3, e_cnt: 3};
        vt[2] = '{b: {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h02, 8'h01, 8'hC4}, len: 3, mode: 0,
                  e_err: 2'd1, e_nout: 0, e_done: 0, e_errp: 1, e_pidv: 0, e_pid: 4'h0, e_cnt: 0};
        vt[3] = '{b: {8'h00, 8'h00, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01, 8'h4B}, len: 6, mode: 0,
                  e_err: 2'd3, e_nout: 4, e_done: 0, e_errp: 1, e_pidv: 1, e_pid: 4'hB, e_cnt: 4};
        vt[4] = '{b: {8'h00, 8'h00, 8'h00, 8'h04, 8'h03, 8'h02, 8'h01, 8'h4B}, len: 5, mode: 1,
                  e_err: 2'd0, e_nout: 4, e_done: 1, e_errp: 0, e_pidv: 1, e_pid: 4'hB, e_cnt: 4};
        vt[5] = '{b: {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hA5}, len: 1, mode: 0,
                  e_err: 2'd0, e_nout: 0, e_done: 1, e_errp: 0, e_pidv: 1, e_pid: 4'h5, e_cnt: 0};

        #1 rst = 1'b1;
        #2;
        check("reset_outputs", 32'({rx_ren, pid, pid_valid, out_data, out_valid, pkt_done, pkt_err,
              err_code, byte_count, busy}), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        model_pid = 4'h0;
        clear_mon();

        // Table-driven packets
        for (int v = 0; v < 6; v++) begin
            q.delete();
            for (int i = 0; i < vt[v].len; i++) q.push_back(vt[v].b[i]);
            send_pkt(q, vt[v].mode, 0);
            check($sformatf("vec%0d_nout", v), got.size(), vt[v].e_nout);
            for (int i = 0; i < vt[v].e_nout && i < got.size(); i++)
                check($sformatf("vec%0d_byte%0d", v, i), got[i], vt[v].b[i + 1]);
            check($sformatf("vec%0d_done", v), done_n, vt[v].e_done);
            check($sformatf("vec%0d_errp", v), errp_n, vt[v].e_errp);
            check($sformatf("vec%0d_pidv", v), pidv_n, vt[v].e_pidv);
            if (vt[v].e_pidv != 0) begin
                model_pid = vt[v].e_pid;
                check($sformatf("vec%0d_pid", v), pidv_val, vt[v].e_pid);
            end
            check($sformatf("vec%0d_code", v), err_code, vt[v].e_err);
            check($sformatf("vec%0d_cnt", v), byte_count, vt[v].e_cnt);
            check($sformatf("vec%0d_busy", v), busy, 1'b0);
            check($sformatf("vec%0d_flushed", v), fifo.size(), 0);
        end

        // Latency: preloaded C3 11 22 33, PID one cycle after its pop, bytes back to back
        clear_mon();
        ready_mode = 0;
        rx_rcving  = 1'b1;
        fifo.push_back(8'hC3); fifo.push_back(8'h11); fifo.push_back(8'h22); fifo.push_back(8'h33);
        repeat (7) cycle_step(1'b0, 8'h00);
        rx_rcving = 1'b0;
        wait_idle("lat");
        model_pid = 4'h3;
        check("lat_pidv_cycle", pidv_cyc, first_pop_cyc + 1);
        check("lat_pid", pidv_val, 4'h3);
        check("lat_nout", got.size(), 3);
        for (int i = 0; i < 3 && i < got.size(); i++) begin
            check("lat_out_cycle", got_cyc[i], first_pop_cyc + 3 + i);
            check("lat_byte", got[i], 8'h11 * (i + 1));
        end
        check("lat_done", done_n, 1);
        check("lat_cnt", byte_count, 3);

        // rx_error in DATA with a byte pending: pkt_err next cycle, byte dropped, FIFO drained
        clear_mon();
        ready_mode = 0;
        rx_rcving  = 1'b1;
        fifo.push_back(8'hA5); fifo.push_back(8'h11); fifo.push_back(8'h22);
        repeat (4) cycle_step(1'b0, 8'h00);
        ready_mode = 3;
        fifo.push_back(8'h33);
        cycle_step(1'b1, 8'h44);
        check("rxerr_pending", out_valid, 1'b1);
        rx_error = 1'b1;
        cycle_step(1'b0, 8'h00);
        rx_error = 1'b0;
        check("rxerr_pkt_err", pkt_err, 1'b1);
        check("rxerr_valid_drop", out_valid, 1'b0);
        check("rxerr_code", err_code, 2'd2);
        ready_mode = 0;
        cycle_step(1'b0, 8'h00);
        rx_rcving = 1'b0;
        wait_idle("rxerr");
        model_pid = 4'h5;
        check("rxerr_nout", got.size(), 1);
        check("rxerr_errp", errp_n, 1);
        check("rxerr_done", done_n, 0);
        check("rxerr_flushed", fifo.size(), 0);
        check("rxerr_code_held", err_code, 2'd2);

        // Random packets against the packet-level model
        for (int t = 0; t < 40; t++) begin
            q.delete();
            p = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 9) < 7) pb = {~p, p};
            else pb = 8'($urandom_range(0, 255));
            q.push_back(pb);
            n = $urandom_range(0, 6);
            for (int i = 0; i < n; i++) q.push_back(8'($urandom_range(0, 255)));
            mode = $urandom_range(0, 2);
            send_pkt(q, mode, $urandom_range(0, 2));
            model_check(q, mode, $sformatf("rnd%0d", t));
        end

        // Reset mid-DATA with a pending byte, then a normal packet
        clear_mon();
        ready_mode = 3;
        rx_rcving  = 1'b1;
        fifo.push_back(8'hC3); fifo.push_back(8'h11); fifo.push_back(8'h22);
        repeat (4) cycle_step(1'b0, 8'h00);
        check("mid_rst_pending", out_valid, 1'b1);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_outputs", 32'({rx_ren, pid, pid_valid, out_data, out_valid, pkt_done, pkt_err,
              err_code, byte_count, busy}), 32'd0);
        fifo.delete();
        rx_rcving = 1'b0;
        drive_fifo();
        @(posedge clk);
        #1 rst = 1'b0;
        model_pid = 4'h0;
        q.delete();
        q.push_back(8'hA5); q.push_back(8'h5A); q.push_back(8'h0F);
        send_pkt(q, 1, 1);
        model_check(q, 1, "post_rst");

        check("ren_while_empty", viol_empty, 0);
        check("ren_while_stalled", viol_stall, 0);
        check("pulse_exclusive", viol_excl, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
